// File: rtl/phasenoisepon_seg7_reader_pkg.sv
// Shared definitions for the seven-segment display reader: legal segment codes,
// default stability window and tracking FSM encoding.
package phasenoisepon_seg7_reader_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    // Segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7C;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h67;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } state_e;

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/phasenoisepon_seg7_reader_seg7_inverse.sv
// Combinational inverse seven-segment decoder: pattern -> {legal, digit}.
module seg7_inverse
    import phasenoisepon_seg7_reader_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'd0;
        case (pattern)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/phasenoisepon_seg7_reader.sv
// Reads a seven-segment display asynchronously: synchronizes, debounces, decodes
// digits and tracks sequence errors and the period between digit changes.
module phasenoisepon_seg7_reader
    import phasenoisepon_seg7_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       invalid,
    output logic [7:0] seq_err_count,
    output logic [9:0] period,
    output logic       period_valid,
    output state_e     fsm_state
);

    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [9:0] GAP_MAX     = 10'h3FF;

    logic [6:0]  s1, s2, s2_prev;
    logic [3:0]  stable_cnt;
    logic [9:0]  gap_cnt;
    logic [10:0] gap_plus;
    logic        same, accept, code_legal;
    logic [3:0]  code_digit;

    seg7_inverse u_inverse (
        .pattern (s2),
        .legal   (code_legal),
        .value   (code_digit)
    );

    // The change cycle itself counts as the first stable cycle, so a pattern
    // seen in s2 for STABLE_CYCLES cycles is accepted exactly once.
    assign same     = (s2 == s2_prev);
    assign accept   = same && (stable_cnt == STABLE_LAST);
    assign gap_plus = {1'b0, gap_cnt} + 11'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1         <= 7'h00;
            s2         <= 7'h00;
            s2_prev    <= 7'h00;
            stable_cnt <= 4'd0;
        end else begin
            s1      <= segments;
            s2      <= s1;
            s2_prev <= s2;
            if (!same)
                stable_cnt <= 4'd1;
            else if (stable_cnt != STABLE_MAX)
                stable_cnt <= stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_state     <= WAIT_FIRST;
            digit         <= 4'd0;
            digit_valid   <= 1'b0;
            new_digit     <= 1'b0;
            invalid       <= 1'b0;
            seq_err_count <= 8'd0;
            period        <= 10'd0;
            period_valid  <= 1'b0;
            gap_cnt       <= 10'd0;
        end else begin
            new_digit <= 1'b0;
            if (gap_cnt != GAP_MAX)
                gap_cnt <= gap_cnt + 10'd1;
            if (accept) begin
                if (!code_legal) begin
                    invalid <= 1'b1;
                end else begin
                    invalid <= 1'b0;
                    if (fsm_state == WAIT_FIRST || code_digit != digit) begin
                        new_digit   <= 1'b1;
                        digit       <= code_digit;
                        digit_valid <= 1'b1;
                        gap_cnt     <= 10'd0;
                        if (fsm_state == WAIT_FIRST) begin
                            fsm_state <= TRACK;
                        end else begin
                            if (code_digit != next_digit(digit) && seq_err_count != 8'hFF)
                                seq_err_count <= seq_err_count + 8'd1;
                            // Distance is gap+1 edges; clamp at the 10-bit limit.
                            period       <= gap_plus[10] ? GAP_MAX : gap_plus[9:0];
                            period_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_phasenoisepon_seg7_reader.sv
// Directed bench for the seven-segment reader with a sampled-history model
// checked every cycle, plus hand-computed expectations.
module tb_phasenoisepon_seg7_reader;
    import phasenoisepon_seg7_reader_pkg::*;

    localparam int STB = 4;
    localparam int HN  = STB + 3;

    logic       clk;
    logic       reset;
    logic [6:0] segments;
    logic [3:0] digit;
    logic       digit_valid, new_digit, invalid, period_valid;
    logic [7:0] seq_err_count;
    logic [9:0] period;
    state_e     fsm_state;

    int total = 0;
    int bad   = 0;
    int nd_seen = 0;
    int base;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

    // model state
    logic [6:0] h [HN];
    int   cyc, last_nd, m_seq, m_period;
    logic [3:0] m_digit;
    bit   m_valid, m_nd, m_inv, m_pv;

    phasenoisepon_seg7_reader #(.STABLE_CYCLES(STB)) dut (
        .clk           (clk),
        .reset         (reset),
        .segments      (segments),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .new_digit     (new_digit),
        .invalid       (invalid),
        .seq_err_count (seq_err_count),
        .period        (period),
        .period_valid  (period_valid),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // model: a pattern is accepted at the edge where it has been sampled on the
    // STB preceding edges (ending two edges back) and was not sampled just before.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int k = 0; k < HN; k++) h[k] = 7'h00;
                cyc = 0; last_nd = 0; m_seq = 0; m_period = 0;
                m_digit = 4'd0; m_valid = 0; m_nd = 0; m_inv = 0; m_pv = 0;
            end else begin
                bit acc, legal;
                logic [6:0] p;
                int val;
                cyc++;
                p = h[2];
                acc = 1;
                for (int k = 2; k <= STB + 1; k++) if (h[k] != p) acc = 0;
                if (h[STB + 2] == p) acc = 0;
                m_nd = 0;
                if (acc) begin
                    legal = 0; val = 0;
                    for (int d = 0; d < 10; d++) if (seg_tab[d] == p) begin legal = 1; val = d; end
                    if (!legal) m_inv = 1;
                    else begin
                        m_inv = 0;
                        if (!m_valid || val != int'(m_digit)) begin
                            if (m_valid) begin
                                if (val != (int'(m_digit) + 1) % 10 && m_seq < 255) m_seq++;
                                m_period = (cyc - last_nd > 1023) ? 1023 : cyc - last_nd;
                                m_pv = 1;
                            end
                            m_digit = 4'(val); m_valid = 1; m_nd = 1; last_nd = cyc;
                        end
                    end
                end
                for (int k = HN - 1; k >= 2; k--) h[k] = h[k-1];
                h[1] = segments;
            end
        end
    end

    // every-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                check("digit", 32'(digit), 32'(m_digit));
                check("digit_valid", 32'(digit_valid), 32'(m_valid));
                check("new_digit", 32'(new_digit), 32'(m_nd));
                check("invalid", 32'(invalid), 32'(m_inv));
                check("seq_err_count", 32'(seq_err_count), 32'(m_seq));
                check("period", 32'(period), 32'(m_period));
                check("period_valid", 32'(period_valid), 32'(m_pv));
                check("fsm_track", 32'(fsm_state == TRACK), 32'(m_valid));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (new_digit) nd_seen++;
        end
    end

    // driver tasks
    task automatic hold(input logic [6:0] pat, input int n);
        segments = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_digit"}, 32'(digit), 32'd0);
        check({tag, "_valid"}, 32'(digit_valid), 32'd0);
        check({tag, "_new"}, 32'(new_digit), 32'd0);
        check({tag, "_inv"}, 32'(invalid), 32'd0);
        check({tag, "_seq"}, 32'(seq_err_count), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_pvalid"}, 32'(period_valid), 32'd0);
        check({tag, "_state"}, 32'(fsm_state == TRACK), 32'd0);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset = 1'b0;
        segments = 7'h00;
        repeat (3) @(negedge clk);
        check_reset_values("rst0");

        // first digit: pulse exactly on edge 6 after the change
        reset = 1'b1;
        segments = 7'h3F;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("first_pulse", 32'(new_digit), 32'(i == 6));
        end
        check("first_digit", 32'(digit), 32'd0);
        check("first_valid", 32'(digit_valid), 32'd1);
        check("first_seq", 32'(seq_err_count), 32'd0);
        check("first_pvalid", 32'(period_valid), 32'd0);

        // full count 1..9,0 at 1001 cycles each
        for (int d = 1; d <= 10; d++) hold(seg_tab[d % 10], 1001);
        check("count_pulses", 32'(nd_seen), 32'd11);
        check("count_period", 32'(period), 32'd1001);
        check("count_pvalid", 32'(period_valid), 32'd1);
        check("count_seq", 32'(seq_err_count), 32'd0);
        check("count_digit", 32'(digit), 32'd0);

        // glitch rejection and acceptance at the stability boundary
        hold(7'h06, 20); hold(7'h5B, 20); hold(7'h4F, 20);
        base = nd_seen;
        hold(7'h06, 3); hold(7'h4F, 20);
        check("glitch3_digit", 32'(digit), 32'd3);
        check("glitch3_pulses", 32'(nd_seen - base), 32'd0);
        hold(7'h06, 4);
        segments = 7'h4F;
        repeat (2) @(negedge clk);
        check("glitch4_digit", 32'(digit), 32'd1);
        check("glitch4_seq", 32'(seq_err_count), 32'd1);
        hold(7'h4F, 20);
        check("back3_digit", 32'(digit), 32'd3);
        check("back3_seq", 32'(seq_err_count), 32'd2);

        // illegal interlude
        hold(7'h66, 20); hold(7'h6D, 20);
        base = nd_seen;
        hold(7'h00, 8);
        check("illegal_inv", 32'(invalid), 32'd1);
        check("illegal_digit", 32'(digit), 32'd5);
        hold(7'h6D, 20);
        check("relegal_inv", 32'(invalid), 32'd0);
        check("relegal_digit", 32'(digit), 32'd5);
        check("relegal_pulses", 32'(nd_seen - base), 32'd0);
        check("relegal_seq", 32'(seq_err_count), 32'd2);

        // saturation of error count and period
        for (int i = 0; i < 600; i++) hold((i % 2) ? 7'h4F : 7'h3F, 20);
        check("sat_seq", 32'(seq_err_count), 32'd255);
        check("alt_period", 32'(period), 32'd20);
        hold(7'h3F, 1100); hold(7'h4F, 20);
        check("sat_period", 32'(period), 32'd1023);
        check("sat_seq_hold", 32'(seq_err_count), 32'd255);

        // reset mid-stream at digit 7
        hold(7'h07, 20);
        check("pre_rst_digit", 32'(digit), 32'd7);
        reset = 1'b0;
        #1;
        check_reset_values("rst1");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("reaccept_pulse", 32'(new_digit), 32'(i == 6));
        end
        check("reaccept_digit", 32'(digit), 32'd7);
        check("reaccept_valid", 32'(digit_valid), 32'd1);
        check("reaccept_seq", 32'(seq_err_count), 32'd0);
        check("reaccept_pvalid", 32'(period_valid), 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phasenoisepon_seg7_reader.md
PHASENOISEPON_SEG7_READER -- requirements
Module: phasenoisepon_seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive sampled cycles a segment pattern must hold before acceptance (legal range 2..15).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 segments  input  7  observed display lines {g,f,e,d,c,b,a}, bit0 = a, asynchronous to clk.
REQ-005 digit  output  4  last accepted decimal digit 0..9.
REQ-006 digit_valid  output  1  high once any legal digit has been accepted since reset.
REQ-007 new_digit  output  1  one-cycle pulse when an accepted digit differs from the held digit, or on the first accepted digit.
REQ-008 invalid  output  1  level; high while the last accepted pattern was not a legal digit.
REQ-009 seq_err_count  output  8  count of out-of-sequence digit changes, saturating at 255.
REQ-010 period  output  10  clock cycles between the last two new_digit events, saturating at 1023.
REQ-011 period_valid  output  1  high once two new_digit events have occurred since reset.

Function
REQ-012 segments SHALL pass through a 2-flop synchronizer; only the second stage (s2) is used.
REQ-013 A stability counter SHALL clear when s2 differs from its previous value and otherwise increment, saturating at STABLE_CYCLES.
REQ-014 A pattern SHALL be accepted exactly once, on the edge where the counter reaches STABLE_CYCLES; latency from input change to output update = 2 + STABLE_CYCLES edges.
REQ-015 Patterns held for fewer than STABLE_CYCLES sampled cycles SHALL have no effect on any output.
REQ-016 Legal table: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7C 7=0x07 8=0x7F 9=0x67; all other 118 codes illegal.
REQ-017 Accepting an illegal code SHALL set invalid, hold digit/digit_valid, and not pulse new_digit.
REQ-018 Accepting a legal code SHALL clear invalid; if code differs from digit or digit_valid is low, update digit and pulse new_digit.
REQ-019 Accepting a legal code equal to the held digit (e.g. after an illegal interlude) SHALL clear invalid only; no pulse, no sequence check.
REQ-020 FSM: WAIT_FIRST (no legal digit yet) -> TRACK on first legal accept; TRACK persists until reset.
REQ-021 In TRACK, on new_digit, if new value != (held + 1) mod 10, seq_err_count SHALL increment (saturating); 9 -> 0 is in sequence.
REQ-022 A 10-bit gap counter SHALL clear on each new_digit and increment per cycle, saturating at 1023.
REQ-023 On a new_digit in TRACK, period SHALL load the cycle distance between this and the previous new_digit edge (saturated 1023), and period_valid SHALL set.
REQ-024 Saturated seq_err_count and period SHALL not wrap.

Reset
REQ-025 While reset is low: synchronizer and s2 history = 0x00, stability counter = 0, FSM = WAIT_FIRST, digit = 0, digit_valid = 0, new_digit = 0, invalid = 0, seq_err_count = 0, period = 0, period_valid = 0, gap counter = 0.
REQ-026 Reset asserted mid-operation SHALL abandon any in-progress acceptance; after release the current input pattern SHALL be accepted after the full 2 + STABLE_CYCLES latency.

Structure
REQ-027 Shared package holds the ten legal segment constants, STABLE_CYCLES default and FSM state encoding.
REQ-028 One combinational sub-module seg7_inverse maps 7-bit pattern -> {legal, digit[3:0]}; all sequential logic in the top module.

Verification
REQ-029 Reset release, segments=0x3F held 10 cycles -> new_digit pulse on edge 6 after change, digit=0, digit_valid=1, seq_err_count=0, period_valid=0.
REQ-030 Drive 0..9,0 each held 1001 cycles -> 11 new_digit pulses, seq_err_count=0, period=1001, period_valid=1.
REQ-031 Digit 3 held, 0x06 glitch for 3 cycles -> no pulse, digit stays 3; same glitch for 4 cycles -> digit=1, seq_err_count=1.
REQ-032 Digit 5 held, then 0x00 held 8 cycles, then 0x6D -> invalid high then low, digit=5 throughout, no new_digit pulse.
REQ-033 Alternate 0x3F/0x4F (0,3) every 20 cycles for 600 transitions -> seq_err_count=255, no wrap; gap >1023 cycles -> period=1023.
REQ-034 Reset low for 1 cycle mid-stream at digit 7 -> all outputs to reset values asynchronously; re-acceptance after 6 edges, seq_err_count not incremented.
